// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_D  = 2'd2
  } arb_state_t;

  // Which requester wins the memory in an idle cycle.
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } arb_grant_t;

  // Memory is word addressed: the two byte-offset bits are always cleared.
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the
// EX/MEM data access. One access is in flight at a time; the done pulses and
// read data are registered, while the stall outputs are combinational so the
// pipeline registers freeze in the same cycle a request is outstanding.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                  STREAK_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(STARVE_MAX);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1'b1);
  localparam logic [STREAK_W-1:0] STREAK_CLR = STREAK_W'(1'b0);
  localparam logic [ADDR_W-1:0]   ADDR_MASK  = {{(ADDR_W-2){1'b1}}, WORD_ALIGN_MASK[1:0]};

  arb_state_t          r_state;
  logic [STREAK_W-1:0] r_streak;

  logic       w_pend_if;
  logic       w_pend_d;
  logic       w_gnt_vld;
  arb_grant_t w_gnt;

  // A request whose done pulses this cycle is already served, so it is not pending.
  assign w_pend_if = if_req & ~if_done;
  assign w_pend_d  = (d_rd | d_wr) & ~d_done;

  assign stall_if  = w_pend_if;
  assign stall_mem = w_pend_d;

  // Idle-cycle grant: data wins a tie unless fetch has waited STARVE_MAX data grants.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = GNT_IF;
    if (r_state == ARB_IDLE) begin
      if (w_pend_d && w_pend_if) begin
        w_gnt_vld = 1'b1;
        w_gnt     = (r_streak == STREAK_SAT) ? GNT_IF : GNT_D;
      end else if (w_pend_d) begin
        w_gnt_vld = 1'b1;
        w_gnt     = GNT_D;
      end else if (w_pend_if) begin
        w_gnt_vld = 1'b1;
        w_gnt     = GNT_IF;
      end else begin
        w_gnt_vld = 1'b0;
        w_gnt     = GNT_IF;
      end
    end else begin
      w_gnt_vld = 1'b0;
      w_gnt     = GNT_IF;
    end
  end

  // Access sequencer: latches the granted request, holds it until mem_ready, returns data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_streak  <= STREAK_CLR;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= {DATA_W{1'b0}};
      d_rdata   <= {DATA_W{1'b0}};
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;

      if (!if_req) begin
        r_streak <= STREAK_CLR;
      end else if (w_gnt_vld && (w_gnt == GNT_IF)) begin
        r_streak <= STREAK_CLR;
      end else if (w_gnt_vld && (w_gnt == GNT_D) && w_pend_if && (r_streak != STREAK_SAT)) begin
        r_streak <= r_streak + STREAK_ONE;
      end else begin
        r_streak <= r_streak;
      end

      case (r_state)
        ARB_IDLE: begin
          if (w_gnt_vld) begin
            mem_valid <= 1'b1;
            if (w_gnt == GNT_D) begin
              mem_addr  <= d_addr & ADDR_MASK;
              mem_we    <= d_wr;
              mem_wdata <= d_wdata;
              r_state   <= ARB_BUSY_D;
            end else begin
              mem_addr  <= if_addr & ADDR_MASK;
              mem_we    <= 1'b0;
              r_state   <= ARB_BUSY_IF;
            end
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_BUSY_IF: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            if_rdata  <= mem_rdata;
            if_done   <= 1'b1;
            r_state   <= ARB_IDLE;
          end else begin
            r_state <= ARB_BUSY_IF;
          end
        end
        ARB_BUSY_D: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            d_done    <= 1'b1;
            // Stores (including rd+wr collisions) leave the load data untouched.
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end else begin
              d_rdata <= d_rdata;
            end
            r_state <= ARB_IDLE;
          end else begin
            r_state <= ARB_BUSY_D;
          end
        end
        default: begin
          mem_valid <= 1'b0;
          mem_we    <= 1'b0;
          r_state   <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
